// File: rtl/axis_stall_watchdog.sv
// Deadlock watchdog for a set of AXI-Stream channels: flags a deadlock once any
// enabled channel stays blocked for THRESH consecutive cycles while work is pending.
module axis_stall_watchdog #(
    parameter int unsigned N_CH   = 4,
    parameter int unsigned N_INST = 3,
    parameter int unsigned THRESH = 16,
    parameter int unsigned CNT_W  = 16,
    localparam int unsigned FC_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N_CH-1:0]   axis_block_sigs,
    input  logic [N_CH-1:0]   ch_enable,
    input  logic [N_INST-1:0] inst_idle_sigs,
    input  logic              clear,
    output logic              block,
    output logic [N_CH-1:0]   block_info,
    output logic [FC_W-1:0]   first_ch,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WATCH    = 2'd1,
        DEADLOCK = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

    state_t            cur_state;
    state_t            next_state;
    logic              all_idle;
    logic [N_CH-1:0]   active;
    logic [N_CH-1:0]   expired;
    logic [CNT_W-1:0]  cnt [N_CH];
    logic [FC_W-1:0]   lowest_expired;
    logic              load_info;
    logic              block_r;
    logic [N_CH-1:0]   block_info_r;
    logic [FC_W-1:0]   first_ch_r;

    assign all_idle = &inst_idle_sigs;

    always_comb begin
        active = axis_block_sigs & ch_enable & {N_CH{~all_idle}};
    end

    always_comb begin
        expired = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            expired[i] = (cnt[i] == THRESH_C);
        end
    end

    always_comb begin
        logic found;
        found          = 1'b0;
        lowest_expired = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (expired[i] && !found) begin
                lowest_expired = FC_W'(i);
                found          = 1'b1;
            end
        end
    end

    // Counters freeze in DEADLOCK; clear zeroes them in every state.
    always_ff @(posedge clock) begin
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (reset || clear) begin
                cnt[i] <= '0;
            end else if (cur_state != DEADLOCK) begin
                if (!active[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] != THRESH_C) begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cur_state <= IDLE;
        end else begin
            cur_state <= next_state;
        end
    end

    always_comb begin
        next_state = cur_state;
        load_info  = 1'b0;
        case (cur_state)
            IDLE: begin
                if (clear) begin
                    next_state = IDLE;
                end else if (|active) begin
                    next_state = WATCH;
                end
            end
            WATCH: begin
                if (clear) begin
                    next_state = IDLE;
                end else if (|expired) begin
                    next_state = DEADLOCK;
                    load_info  = 1'b1;
                end else if (!(|active)) begin
                    next_state = IDLE;
                end
            end
            DEADLOCK: begin
                if (clear) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            block_r      <= 1'b0;
            block_info_r <= '0;
            first_ch_r   <= '0;
        end else begin
            block_r <= (next_state == DEADLOCK);
            if (load_info) begin
                block_info_r <= expired;
                first_ch_r   <= lowest_expired;
            end else if (cur_state == DEADLOCK && clear) begin
                block_info_r <= '0;
                first_ch_r   <= '0;
            end
        end
    end

    assign block      = block_r;
    assign block_info = block_info_r;
    assign first_ch   = first_ch_r;
    assign state      = cur_state;

endmodule

// File: tb/tb_axis_stall_watchdog.sv
// Directed bench for axis_stall_watchdog (THRESH=4): stimulus queues expected
// outputs per cycle, a negedge monitor pops and compares them.
module tb_axis_stall_watchdog;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] axis_block_sigs;
    logic [3:0] ch_enable;
    logic [2:0] inst_idle_sigs;
    logic       clear;
    logic       block;
    logic [3:0] block_info;
    logic [1:0] first_ch;
    logic [1:0] state;

    typedef struct {
        int unsigned at;
        string       name;
        logic        blk;
        logic [1:0]  st;
        logic        chk_info;
        logic [3:0]  info;
        logic [1:0]  fc;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int unsigned cyc   = 0;
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    axis_stall_watchdog #(
        .N_CH   (4),
        .N_INST (3),
        .THRESH (4),
        .CNT_W  (16)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .axis_block_sigs (axis_block_sigs),
        .ch_enable       (ch_enable),
        .inst_idle_sigs  (inst_idle_sigs),
        .clear           (clear),
        .block           (block),
        .block_info      (block_info),
        .first_ch        (first_ch),
        .state           (state)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_out(input string nm, input logic b, input logic [1:0] s);
        exp_t x;
        x.at = cyc; x.name = nm; x.blk = b; x.st = s;
        x.chk_info = 1'b0; x.info = '0; x.fc = '0;
        sb.push_back(x);
    endtask

    task automatic expect_full(input string nm, input logic b, input logic [1:0] s,
                               input logic [3:0] info, input logic [1:0] fc);
        exp_t x;
        x.at = cyc; x.name = nm; x.blk = b; x.st = s;
        x.chk_info = 1'b1; x.info = info; x.fc = fc;
        sb.push_back(x);
    endtask

    task automatic watch_n(input string nm, input int unsigned n);
        for (int unsigned k = 0; k < n; k++) begin
            tick();
            expect_out(nm, 1'b0, 2'd1);
        end
    endtask

    task automatic idle_n(input string nm, input int unsigned n);
        for (int unsigned k = 0; k < n; k++) begin
            tick();
            expect_out(nm, 1'b0, 2'd0);
        end
    endtask

    task automatic do_clear(input string nm);
        axis_block_sigs = 4'b0000;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        expect_out(nm, 1'b0, 2'd0);
    endtask

    // Monitor: compares every queued expectation due at this cycle.
    initial begin
        forever begin
            @(negedge clock);
            while (sb.size() > 0 && sb[0].at <= cyc) begin
                e = sb.pop_front();
                n_cmp++;
                if (e.at != cyc) begin
                    n_err++;
                    $display("FAIL %s: check for cycle %0d missed, now cycle %0d", e.name, e.at, cyc);
                end else if (block !== e.blk || state !== e.st ||
                             (e.chk_info && (block_info !== e.info || first_ch !== e.fc))) begin
                    n_err++;
                    $display("FAIL %s @cyc %0d: got block=%b state=%0d info=%b first=%0d, want block=%b state=%0d info=%b first=%0d%s",
                             e.name, cyc, block, state, block_info, first_ch,
                             e.blk, e.st, e.info, e.fc, e.chk_info ? "" : " (info not checked)");
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; clear = 1'b0; axis_block_sigs = 4'b0000;
        ch_enable = 4'hF; inst_idle_sigs = 3'b000;
        tick();
        expect_full("reset", 1'b0, 2'd0, 4'b0000, 2'd0);
        reset = 1'b0;
        idle_n("quiet", 1);

        // Single channel held blocked: deadlock at the 5th edge.
        axis_block_sigs = 4'b0100;
        watch_n("t1_watch", 4);
        tick();
        expect_full("t1_dead", 1'b1, 2'd2, 4'b0100, 2'd2);
        axis_block_sigs = 4'b0000;
        tick();
        expect_full("t1_hold", 1'b1, 2'd2, 4'b0100, 2'd2);
        do_clear("t1_clear");

        // Short stalls never reach the threshold.
        axis_block_sigs = 4'b0010;
        watch_n("t2_watch_a", 3);
        axis_block_sigs = 4'b0000;
        idle_n("t2_idle_a", 1);
        axis_block_sigs = 4'b0010;
        watch_n("t2_watch_b", 3);
        axis_block_sigs = 4'b0000;
        idle_n("t2_idle_b", 1);

        // Two channels expiring together; outputs hold until clear.
        axis_block_sigs = 4'b1001;
        watch_n("t3_watch", 4);
        tick();
        expect_full("t3_dead", 1'b1, 2'd2, 4'b1001, 2'd0);
        for (int unsigned k = 0; k < 20; k++) begin
            if (k == 10) axis_block_sigs = 4'b0000;
            tick();
            expect_full("t3_hold", 1'b1, 2'd2, 4'b1001, 2'd0);
        end
        do_clear("t3_clear");

        // Masked channel and all-idle never count.
        axis_block_sigs = 4'b0100; ch_enable = 4'b1011;
        idle_n("t4_masked", 10);
        ch_enable = 4'hF; inst_idle_sigs = 3'b111;
        idle_n("t4_allidle", 10);
        inst_idle_sigs = 3'b011;
        watch_n("t4_watch", 4);
        tick();
        expect_full("t4_dead", 1'b1, 2'd2, 4'b0100, 2'd2);
        do_clear("t4_clear");
        inst_idle_sigs = 3'b000;

        // Disabling a channel mid-count restarts it.
        axis_block_sigs = 4'b0100;
        watch_n("t5_watch_a", 3);
        ch_enable = 4'b1011;
        idle_n("t5_disabled", 1);
        ch_enable = 4'hF;
        watch_n("t5_watch_b", 4);
        tick();
        expect_full("t5_dead", 1'b1, 2'd2, 4'b0100, 2'd2);
        do_clear("t5_clear");

        // Clear on the expiry cycle wins; held block re-asserts later.
        axis_block_sigs = 4'b0010;
        watch_n("t6_watch_a", 4);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        expect_out("t6_clear_wins", 1'b0, 2'd0);
        watch_n("t6_watch_b", 4);
        tick();
        expect_full("t6_dead", 1'b1, 2'd2, 4'b0010, 2'd1);

        // Reset in DEADLOCK discards everything, counting restarts from zero.
        reset = 1'b1;
        tick();
        expect_full("t7_reset", 1'b0, 2'd0, 4'b0000, 2'd0);
        reset = 1'b0;
        watch_n("t7_watch", 4);
        tick();
        expect_full("t7_dead", 1'b1, 2'd2, 4'b0010, 2'd1);
        axis_block_sigs = 4'b0000; reset = 1'b1;
        tick();
        expect_full("t7_reset_b", 1'b0, 2'd0, 4'b0000, 2'd0);
        reset = 1'b0;

        // Clear while watching forces IDLE and zeroes counters.
        axis_block_sigs = 4'b0001;
        watch_n("t8_watch_a", 2);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        expect_out("t8_clear", 1'b0, 2'd0);
        watch_n("t8_watch_b", 4);
        tick();
        expect_full("t8_dead", 1'b1, 2'd2, 4'b0001, 2'd0);
        do_clear("t8_clear_b");

        // All instances idle mid-count zeroes the counters.
        axis_block_sigs = 4'b1000;
        watch_n("t9_watch_a", 3);
        inst_idle_sigs = 3'b111;
        idle_n("t9_allidle", 1);
        inst_idle_sigs = 3'b000;
        watch_n("t9_watch_b", 4);
        tick();
        expect_full("t9_dead", 1'b1, 2'd2, 4'b1000, 2'd3);
        do_clear("t9_clear");

        for (int unsigned k = 0; k < 5 && sb.size() > 0; k++) tick();
        if (sb.size() > 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations never checked, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
